// File: rtl/jtag_dmi_master.sv
// JTAG bit-bang master: converts DMI requests into TCK/TMS/TDI scans for a dmi_jtag TAP
// and returns the DMI response captured from TDO.
module jtag_dmi_master #(
  parameter int unsigned          ClkDiv     = 2,
  parameter int unsigned          IdleCycles = 5,
  parameter int unsigned          IrLength   = 5,
  parameter logic [IrLength-1:0]  DmiIr      = 'h11,
  parameter int unsigned          AbitsWidth = 7
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [AbitsWidth-1:0] req_addr_i,
  input  logic [1:0]            req_op_i,
  input  logic [31:0]           req_data_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [31:0]           resp_data_o,
  output logic [1:0]            resp_op_o,
  output logic                  busy_o,
  output logic                  tck_o,
  output logic                  tms_o,
  output logic                  tdi_o,
  output logic                  trst_no,
  input  logic                  tdo_i
);

  localparam int unsigned DrLen     = AbitsWidth + 34;
  localparam int unsigned DrScanLen = DrLen + 5;
  localparam int unsigned IrScanLen = IrLength + 6;
  localparam int unsigned MaxLen0   = (DrScanLen > IrScanLen) ? DrScanLen : IrScanLen;
  localparam int unsigned MaxLen1   = (MaxLen0 > IdleCycles) ? MaxLen0 : IdleCycles;
  localparam int unsigned MaxLen    = (MaxLen1 > 7) ? MaxLen1 : 7;
  localparam int unsigned CntW      = $clog2(MaxLen);
  localparam int unsigned DivW      = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;

  typedef enum logic [2:0] {
    StResetTap, StIdle, StIrScan, StDrReq, StRtiWait, StDrResp, StResp
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DivW-1:0]   div_q, div_d;
  logic              tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d, trst_q, trst_d;
  logic              ready_q, ready_d, busy_q, busy_d, rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rop_q, rop_d;
  logic [DrLen-1:0]  req_q, req_d, cap_q, cap_d;
  logic              ir_loaded_q, ir_loaded_d;
  logic              running, tick, rise, fall;
  logic [1:0]        nxt;
  int unsigned       cnt_int;
  logic              unused_cap;

  // Number of TCK periods spent in each scanning state.
  function automatic int unsigned period_len(state_e st);
    case (st)
      StResetTap:          return 7;
      StIrScan:            return IrScanLen;
      StDrReq, StDrResp:   return DrScanLen;
      StRtiWait:           return IdleCycles;
      default:             return 1;
    endcase
  endfunction

  // TMS/TDI for TCK period idx of state st; result is {tms, tdi}.
  function automatic logic [1:0] drive(state_e st, int unsigned idx, logic [DrLen-1:0] vec);
    logic                tms, tdi;
    logic [DrLen-1:0]    sh;
    logic [IrLength-1:0] ir_sh;
    tms   = 1'b0;
    tdi   = 1'b0;
    sh    = vec >> (idx - 3);
    ir_sh = DmiIr >> (idx - 4);
    case (st)
      StResetTap: tms = (idx != 6);
      StIrScan: begin
        if (idx < 2) begin
          tms = 1'b1;
        end else if (idx >= 4 && idx < 4 + IrLength) begin
          tdi = ir_sh[0];
          tms = (idx == 3 + IrLength);
        end else if (idx == 4 + IrLength) begin
          tms = 1'b1;
        end
      end
      StDrReq, StDrResp: begin
        if (idx == 0) begin
          tms = 1'b1;
        end else if (idx >= 3 && idx < 3 + DrLen) begin
          tdi = sh[0];
          tms = (idx == 2 + DrLen);
        end else if (idx == 3 + DrLen) begin
          tms = 1'b1;
        end
      end
      default: ;
    endcase
    return {tms, tdi};
  endfunction

  // TCK is parked low while idle and while waiting for the response to be taken.
  assign running    = (state_q != StIdle) && (state_q != StResp);
  assign tick       = running && (div_q == DivW'(ClkDiv - 1));
  assign rise       = tick && !tck_q;
  assign fall       = tick && tck_q;
  assign unused_cap = ^cap_q[DrLen-1:34];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = '0;
    tck_d       = tck_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    trst_d      = trst_q;
    rvalid_d    = rvalid_q;
    rdata_d     = rdata_q;
    rop_d       = rop_q;
    req_d       = req_q;
    cap_d       = cap_q;
    ir_loaded_d = ir_loaded_q;
    nxt         = 2'b00;
    cnt_int     = 32'(cnt_q);

    if (running && !tick) begin
      div_d = div_q + 1'b1;
    end

    if (rise) begin
      tck_d = 1'b1;
      if (state_q == StDrResp && cnt_int >= 3 && cnt_int < 3 + DrLen) begin
        cap_d = {tdo_i, cap_q[DrLen-1:1]};
      end
    end

    if (fall) begin
      tck_d  = 1'b0;
      trst_d = 1'b1;
      if (cnt_int == period_len(state_q) - 1) begin
        cnt_d = '0;
        case (state_q)
          StResetTap: state_d = StIdle;
          StIrScan: begin
            state_d     = StDrReq;
            ir_loaded_d = 1'b1;
          end
          StDrReq:    state_d = StRtiWait;
          StRtiWait: begin
            state_d = StDrResp;
            req_d   = '0;
          end
          StDrResp: begin
            state_d  = StResp;
            rvalid_d = 1'b1;
            rdata_d  = cap_q[33:2];
            rop_d    = cap_q[1:0];
          end
          default: ;
        endcase
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      nxt   = drive(state_d, 32'(cnt_d), req_d);
      tms_d = nxt[1];
      tdi_d = nxt[0];
    end

    if (state_q == StIdle && req_valid_i && ready_q) begin
      req_d   = {req_addr_i, req_data_i, req_op_i};
      state_d = ir_loaded_q ? StDrReq : StIrScan;
      cnt_d   = '0;
      nxt     = drive(state_d, 0, req_d);
      tms_d   = nxt[1];
      tdi_d   = nxt[0];
    end

    if (state_q == StResp && resp_ready_i) begin
      state_d  = StIdle;
      rvalid_d = 1'b0;
    end

    ready_d = (state_d == StIdle);
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StResetTap;
      cnt_q       <= '0;
      div_q       <= '0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      trst_q      <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rop_q       <= '0;
      req_q       <= '0;
      cap_q       <= '0;
      ir_loaded_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      trst_q      <= trst_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rop_q       <= rop_d;
      req_q       <= req_d;
      cap_q       <= cap_d;
      ir_loaded_q <= ir_loaded_d;
    end
  end

  assign req_ready_o  = ready_q;
  assign busy_o       = busy_q;
  assign resp_valid_o = rvalid_q;
  assign resp_data_o  = rdata_q;
  assign resp_op_o    = rop_q;
  assign tck_o        = tck_q;
  assign tms_o        = tms_q;
  assign tdi_o        = tdi_q;
  assign trst_no      = trst_q;

endmodule

// File: tb/tb_jtag_dmi_master.sv
// Bench for jtag_dmi_master: a behavioural TAP + DMI target on the JTAG pins and a
// request-level reference model for the expected responses.
module tb_jtag_dmi_master;

  localparam logic [4:0] DmiIr = 5'h11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready_o;
  logic [6:0]  req_addr = '0;
  logic [1:0]  req_op = '0;
  logic [31:0] req_data = '0;
  logic        resp_valid_o, resp_ready = 1'b0;
  logic [31:0] resp_data_o;
  logic [1:0]  resp_op_o;
  logic        busy_o, tck_o, tms_o, tdi_o, trst_no;
  logic        tdo = 1'b0;

  always #5 clk = ~clk;

  jtag_dmi_master dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready_o),
    .req_addr_i   (req_addr),
    .req_op_i     (req_op),
    .req_data_i   (req_data),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready),
    .resp_data_o  (resp_data_o),
    .resp_op_o    (resp_op_o),
    .busy_o       (busy_o),
    .tck_o        (tck_o),
    .tms_o        (tms_o),
    .tdi_o        (tdi_o),
    .trst_no      (trst_no),
    .tdo_i        (tdo)
  );

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input logic [6:0] a);
    return (a == 7'h11) ? 32'h0040_0c82 : {25'h15f00c, a};
  endfunction

  // ---------------- TAP + DMI target model ----------------
  typedef enum int {Tlr, Rti, SelDr, CapDr, ShDr, Ex1Dr, PauDr, Ex2Dr, UpdDr,
                    SelIr, CapIr, ShIr, Ex1Ir, PauIr, Ex2Ir, UpdIr} tap_e;
  tap_e        tap_st = Tlr;
  logic [4:0]  tap_ir = 5'h01, ir_sr = '0;
  logic [40:0] dr_sr = '0;
  logic [40:0] dr_log[$];
  int          ir_updates = 0;
  logic [31:0] dev_mem [128];
  bit          dev_written [128];
  logic [31:0] dev_rdata = '0;
  logic [1:0]  dev_status = '0;
  logic [6:0]  dev_addr = '0;
  bit          force_busy = 1'b0;

  function automatic tap_e tap_next(input tap_e s, input logic tms);
    case (s)
      Tlr:   return tms ? Tlr   : Rti;
      Rti:   return tms ? SelDr : Rti;
      SelDr: return tms ? SelIr : CapDr;
      CapDr: return tms ? Ex1Dr : ShDr;
      ShDr:  return tms ? Ex1Dr : ShDr;
      Ex1Dr: return tms ? UpdDr : PauDr;
      PauDr: return tms ? Ex2Dr : PauDr;
      Ex2Dr: return tms ? UpdDr : ShDr;
      UpdDr: return tms ? SelDr : Rti;
      SelIr: return tms ? Tlr   : CapIr;
      CapIr: return tms ? Ex1Ir : ShIr;
      ShIr:  return tms ? Ex1Ir : ShIr;
      Ex1Ir: return tms ? UpdIr : PauIr;
      PauIr: return tms ? Ex2Ir : PauIr;
      Ex2Ir: return tms ? UpdIr : ShIr;
      default: return tms ? SelDr : Rti;
    endcase
  endfunction

  always @(posedge tck_o or negedge trst_no) begin
    if (!trst_no) begin
      tap_st <= Tlr;
      tap_ir <= 5'h01;
    end else begin
      case (tap_st)
        Tlr:   tap_ir <= 5'h01;
        CapDr: dr_sr <= (tap_ir == DmiIr) ? {dev_addr, dev_rdata, dev_status} : '0;
        ShDr:  dr_sr <= {tdi_o, dr_sr[40:1]};
        CapIr: ir_sr <= 5'b00001;
        ShIr:  ir_sr <= {tdi_o, ir_sr[4:1]};
        UpdIr: begin
          tap_ir     <= ir_sr;
          ir_updates <= ir_updates + 1;
        end
        UpdDr: if (tap_ir == DmiIr) begin
          dr_log.push_back(dr_sr);
          dev_addr <= dr_sr[40:34];
          if (force_busy) begin
            dev_status <= 2'd3;
          end else begin
            dev_status <= 2'd0;
            if (dr_sr[1:0] == 2'd1) begin
              dev_rdata <= dev_written[dr_sr[40:34]] ? dev_mem[dr_sr[40:34]]
                                                     : init_word(dr_sr[40:34]);
            end else if (dr_sr[1:0] == 2'd2) begin
              dev_mem[dr_sr[40:34]]     <= dr_sr[33:2];
              dev_written[dr_sr[40:34]] <= 1'b1;
              dev_rdata                 <= '0;
            end
          end
        end
        default: ;
      endcase
      tap_st <= tap_next(tap_st, tms_o);
    end
  end

  always @(negedge tck_o) begin
    tdo <= (tap_st == ShDr) ? dr_sr[0] : (tap_st == ShIr) ? ir_sr[0] : 1'b0;
  end

  // TMS/TDI must never move on an edge that leaves TCK high.
  logic tms_prev = 1'b1, tdi_prev = 1'b0;
  int   edge_viol = 0;
  always @(negedge clk) begin
    if (rst_n && tck_o && (tms_o !== tms_prev || tdi_o !== tdi_prev)) edge_viol <= edge_viol + 1;
    tms_prev <= tms_o;
    tdi_prev <= tdi_o;
  end

  // ---------------- reference model (request level) ----------------
  logic [31:0] ref_mem [int];
  logic [31:0] last_data = '0;

  task automatic ref_apply(input logic [6:0] a, input logic [1:0] op, input logic [31:0] d,
                           input bit busy, output logic [31:0] ed, output logic [1:0] es);
    if (busy) begin
      es = 2'd3;
      ed = last_data;
    end else begin
      es = 2'd0;
      if (op == 2'd1) ed = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(a);
      else if (op == 2'd2) begin
        ref_mem[int'(a)] = d;
        ed = '0;
      end else ed = last_data;
    end
    last_data = ed;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int unsigned obs, input int unsigned lo,
                         input int unsigned hi);
    total++;
    assert (obs >= lo && obs <= hi) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic chk_reset_vals(input string when);
    chk({when, "_tck"}, tck_o, 1'b0);
    chk({when, "_tms"}, tms_o, 1'b1);
    chk({when, "_tdi"}, tdi_o, 1'b0);
    chk({when, "_trst"}, trst_no, 1'b0);
    chk({when, "_req_ready"}, req_ready_o, 1'b0);
    chk({when, "_resp_valid"}, resp_valid_o, 1'b0);
    chk({when, "_resp_data"}, resp_data_o, 32'h0);
    chk({when, "_resp_op"}, resp_op_o, 2'd0);
    chk({when, "_busy"}, busy_o, 1'b0);
  endtask

  task automatic reset_release_checks();
    int unsigned c0, n;
    @(negedge clk);
    rst_n = 1'b1;
    c0 = cyc;
    n = 0;
    while (trst_no !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("trst_low_clk", cyc - c0, 4);
    while (req_ready_o !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk_rng("ready_after_reset", cyc - c0, 26, 30);
    chk("tap_in_rti", tap_st == Rti, 1'b1);
  endtask

  task automatic do_txn(input logic [6:0] a, input logic [1:0] op, input logic [31:0] d,
                        input bit busy, input int unsigned hold, input bit ir_expected);
    int unsigned n, c0, lat, exp_lat, ir0, ready_viol, busy_viol, stab_viol;
    logic [31:0] ed, sd;
    logic [1:0]  es, so;
    logic [40:0] got0, got1;
    ref_apply(a, op, d, busy, ed, es);
    force_busy = busy;
    ir0 = ir_updates;
    dr_log.delete();
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_op = op; req_data = d;
    n = 0;
    while (req_ready_o !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    chk("req_ready_wait", req_ready_o, 1'b1);
    @(posedge clk);
    @(negedge clk);
    c0 = cyc;
    // a stray request held while busy must be ignored
    req_addr = ~a; req_data = ~d; req_op = 2'd1;
    ready_viol = 0; busy_viol = 0; n = 0;
    while (resp_valid_o !== 1'b1 && n < 1000) begin
      if (req_ready_o !== 1'b0) ready_viol++;
      if (busy_o !== 1'b1) busy_viol++;
      @(negedge clk);
      n++;
    end
    lat = cyc - c0;
    req_valid = 1'b0;
    exp_lat = ir_expected ? 432 : 388;
    chk_rng("resp_latency", lat, exp_lat - 2, exp_lat + 2);
    chk("stray_req_ignored", ready_viol, 0);
    chk("busy_inflight", busy_viol, 0);
    chk("resp_data", resp_data_o, ed);
    chk("resp_op", resp_op_o, es);
    chk("dr_scan_count", dr_log.size(), 2);
    got0 = (dr_log.size() > 0) ? dr_log[0] : 'x;
    got1 = (dr_log.size() > 1) ? dr_log[1] : 'x;
    chk("dr_req_word", got0, {a, d, op});
    chk("dr_resp_word", got1, 41'h0);
    chk("ir_scan_count", ir_updates - ir0, ir_expected ? 1 : 0);
    sd = resp_data_o; so = resp_op_o; stab_viol = 0;
    repeat (hold) begin
      @(negedge clk);
      if (resp_data_o !== sd || resp_op_o !== so || resp_valid_o !== 1'b1 ||
          tck_o !== 1'b0 || req_ready_o !== 1'b0) stab_viol++;
    end
    chk("resp_hold_stable", stab_viol, 0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("after_resp_hs", {req_ready_o, resp_valid_o, busy_o}, 3'b100);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset_release_checks();

    do_txn(7'h10, 2'd2, 32'h0000_0001, 1'b0, 0, 1'b1);
    chk("ir_value", tap_ir, DmiIr);
    do_txn(7'h11, 2'd1, 32'h0, 1'b0, 50, 1'b0);
    do_txn(7'h10, 2'd1, 32'h0, 1'b0, 3, 1'b0);
    do_txn(7'h20, 2'd2, 32'hcafe_f00d, 1'b1, 5, 1'b0);
    do_txn(7'h20, 2'd1, 32'h0, 1'b0, 1, 1'b0);
    do_txn(7'h00, 2'd0, 32'h0, 1'b0, 2, 1'b0);

    for (int i = 0; i < 8; i++) begin
      do_txn(7'($urandom_range(16, 31)), 2'($urandom_range(0, 2)), $urandom,
             ($urandom_range(0, 4) == 0), $urandom_range(0, 20), 1'b0);
    end

    // Abort a write half-way through its DR shift with an asynchronous reset.
    force_busy = 1'b0;
    dr_log.delete();
    @(negedge clk);
    req_valid = 1'b1; req_addr = 7'h05; req_op = 2'd2; req_data = 32'hdead_beef;
    n = 0;
    while (req_ready_o !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (80) @(negedge clk);
    chk("mid_scan_busy", busy_o, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("async");
    chk("aborted_no_update", dr_log.size(), 0);
    repeat (3) @(negedge clk);
    reset_release_checks();
    do_txn(7'h05, 2'd1, 32'h0, 1'b0, 2, 1'b1);
    do_txn(7'h10, 2'd1, 32'h0, 1'b0, 0, 1'b0);

    chk("tms_tdi_edge", edge_viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
